// File: rtl/wb_region_decoder_pkg.sv
// Shared constants, state encoding and helpers for the Wishbone region decoder.
// Default geometry: 4 regions of 4 KiB at 0x3000_0000, done strobe at 0x3000_3100.
package wb_region_decoder_pkg;

  localparam logic [31:0] BASE_ADDR_DEF   = 32'h3000_0000;
  localparam int          NUM_REGIONS_DEF = 4;
  localparam int          SEL_LSB_DEF     = 12;
  localparam int          SUB_LSB_DEF     = 4;
  localparam int          SUB_W_DEF       = 5;
  localparam logic [31:0] DONE_ADDR_DEF   = 32'h3000_3100;
  localparam int          TIMEOUT_DEF     = 15;

  // Read data returned for unmapped or abandoned accesses.
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_RESP_ERR
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_region_decoder_if.sv
// Wishbone classic slave bus as seen by the region decoder (Caravel wbs_* naming).
interface wb_region_decoder_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_region_decoder_index.sv
// Combinational address split: window match, region index, param-bank sub-index, offset.
module wb_region_index
  import wb_region_decoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          NUM_REGIONS = NUM_REGIONS_DEF,
  parameter int          SEL_LSB     = SEL_LSB_DEF,
  parameter int          SUB_LSB     = SUB_LSB_DEF,
  parameter int          SUB_W       = SUB_W_DEF
) (
  input  logic [31:0]                    i_adr,
  output logic                           o_in_range,
  output logic [$clog2(NUM_REGIONS)-1:0] o_idx,
  output logic [SUB_W-1:0]               o_sub,
  output logic [SEL_LSB-1:0]             o_off
);

  localparam int HI_LSB = SEL_LSB + $clog2(NUM_REGIONS);

  // Every bit above the region index must match the window base.
  assign o_in_range = (i_adr >> HI_LSB) == (BASE_ADDR >> HI_LSB);
  assign o_idx      = i_adr[SEL_LSB +: $clog2(NUM_REGIONS)];
  assign o_sub      = i_adr[SUB_LSB +: SUB_W];
  assign o_off      = i_adr[SEL_LSB-1:0];

endmodule

// File: rtl/wb_region_decoder.sv
// Registered Wishbone front end: decodes into one-hot region requests and returns ack/data.
// Optional macro WB_DECODER_TIMEOUT_EN forces an error response after TIMEOUT REQ cycles.
module wb_region_decoder
  import wb_region_decoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          NUM_REGIONS = NUM_REGIONS_DEF,
  parameter int          SEL_LSB     = SEL_LSB_DEF,
  parameter int          SUB_LSB     = SUB_LSB_DEF,
  parameter int          SUB_W       = SUB_W_DEF,
  parameter logic [31:0] DONE_ADDR   = DONE_ADDR_DEF
`ifdef WB_DECODER_TIMEOUT_EN
  ,
  parameter int          TIMEOUT     = TIMEOUT_DEF
`endif
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  wb_region_decoder_if.slave          wbs,
  output logic [NUM_REGIONS-1:0]      rgn_sel_o,
  output logic [SUB_W-1:0]            rgn_sub_o,
  output logic [SEL_LSB-1:0]          rgn_off_o,
  output logic                        rgn_we_o,
  output logic [3:0]                  rgn_be_o,
  output logic [31:0]                 rgn_wdata_o,
  input  logic [NUM_REGIONS-1:0]      rgn_ack_i,
  input  logic [NUM_REGIONS*32-1:0]   rgn_rdata_i,
  output logic                        done_pulse_o,
  output logic [7:0]                  err_cnt_o
);

  localparam int RW = $clog2(NUM_REGIONS);

  state_e                 r_state, w_state_nxt;
  logic                   w_in_range;
  logic [RW-1:0]          w_idx;
  logic [SUB_W-1:0]       w_sub;
  logic [SEL_LSB-1:0]     w_off;
  logic                   w_accept, w_grant, w_tmo_hit, w_ack_sel;
  logic [31:0]            w_rdata_sel;

  logic [RW-1:0]          r_idx;
  logic                   r_done_hit;
  logic [NUM_REGIONS-1:0] r_sel;
  logic [SUB_W-1:0]       r_sub;
  logic [SEL_LSB-1:0]     r_off;
  logic                   r_we;
  logic [3:0]             r_be;
  logic [31:0]            r_wdata, r_rdata, r_dat;
  logic                   r_ack, r_done;
  logic [7:0]             r_err_cnt;

  wb_region_index #(
    .BASE_ADDR   (BASE_ADDR),
    .NUM_REGIONS (NUM_REGIONS),
    .SEL_LSB     (SEL_LSB),
    .SUB_LSB     (SUB_LSB),
    .SUB_W       (SUB_W)
  ) u_index (
    .i_adr      (wbs.wbs_adr_i),
    .o_in_range (w_in_range),
    .o_idx      (w_idx),
    .o_sub      (w_sub),
    .o_off      (w_off)
  );

  // Only the pending region's ack counts; strays from other regions are ignored.
  assign w_ack_sel = rgn_ack_i[r_idx];

  always_comb begin
    w_rdata_sel = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_idx == RW'(i)) w_rdata_sel = rgn_rdata_i[i*32 +: 32];
    end
  end

`ifdef WB_DECODER_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                r_tmo_cnt <= '0;
    else if (r_state != ST_REQ)  r_tmo_cnt <= '0;
    else                         r_tmo_cnt <= r_tmo_cnt + 8'd1;
  end

  assign w_tmo_hit = (r_tmo_cnt == 8'(TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The !ack term stops the still-asserted stb of the finished access being re-taken.
        if (wbs.wbs_cyc_i && wbs.wbs_stb_i && !r_ack) begin
          w_accept    = 1'b1;
          w_state_nxt = w_in_range ? ST_REQ : ST_RESP_ERR;
        end
      end
      ST_REQ: begin
        if (!wbs.wbs_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_ack_sel) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_RESP_ERR;
        end
      end
      ST_RESP, ST_RESP_ERR: w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_idx      <= '0;
      r_done_hit <= 1'b0;
      r_sel      <= '0;
      r_sub      <= '0;
      r_off      <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_dat      <= '0;
      r_ack      <= 1'b0;
      r_done     <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      if (w_accept) begin
        r_idx      <= w_idx;
        r_sub      <= w_sub;
        r_off      <= w_off;
        r_we       <= wbs.wbs_we_i;
        r_be       <= wbs.wbs_sel_i;
        r_wdata    <= wbs.wbs_dat_i;
        r_done_hit <= (wbs.wbs_adr_i == DONE_ADDR);
        r_sel      <= w_in_range ? (NUM_REGIONS'(1) << w_idx) : '0;
      end
      if (r_state == ST_REQ && w_state_nxt != ST_REQ) r_sel <= '0;
      if (w_grant) r_rdata <= w_rdata_sel;
      if (r_state == ST_RESP) begin
        r_ack  <= 1'b1;
        r_dat  <= r_we ? '0 : r_rdata;
        r_done <= r_we && r_done_hit;
      end
      if (r_state == ST_RESP_ERR) begin
        r_ack     <= 1'b1;
        r_dat     <= ERR_DATA;
        r_err_cnt <= sat_inc8(r_err_cnt);
      end
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign rgn_sel_o     = r_sel;
  assign rgn_sub_o     = r_sub;
  assign rgn_off_o     = r_off;
  assign rgn_we_o      = r_we;
  assign rgn_be_o      = r_be;
  assign rgn_wdata_o   = r_wdata;
  assign done_pulse_o  = r_done;
  assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_wb_region_decoder.sv
// Self-checking bench for wb_region_decoder: randomized accesses against a window/region model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wb_region_decoder;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] DONE_A   = 32'h3000_3100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_region_decoder_if bus ();

  logic [3:0]   rgn_sel_o;
  logic [4:0]   rgn_sub_o;
  logic [11:0]  rgn_off_o;
  logic         rgn_we_o;
  logic [3:0]   rgn_be_o;
  logic [31:0]  rgn_wdata_o;
  logic [3:0]   rgn_ack_i;
  logic [127:0] rgn_rdata_i;
  logic         done_pulse_o;
  logic [7:0]   err_cnt_o;

  wb_region_decoder dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs          (bus),
    .rgn_sel_o    (rgn_sel_o),
    .rgn_sub_o    (rgn_sub_o),
    .rgn_off_o    (rgn_off_o),
    .rgn_we_o     (rgn_we_o),
    .rgn_be_o     (rgn_be_o),
    .rgn_wdata_o  (rgn_wdata_o),
    .rgn_ack_i    (rgn_ack_i),
    .rgn_rdata_i  (rgn_rdata_i),
    .done_pulse_o (done_pulse_o),
    .err_cnt_o    (err_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_err = 0;
  logic [31:0] lane [4];

  // Window 0x3000_0000..0x3000_3FFF holds four 4 KiB regions; anything else is unmapped.
  function automatic int region_of(input logic [31:0] adr);
    if (adr < 32'h3000_0000 || adr >= 32'h3000_4000) return -1;
    return int'((adr - 32'h3000_0000) / 4096);
  endfunction

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
  endtask

  task automatic bus_start(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      lane[i] = $urandom;
      rgn_rdata_i[i*32 +: 32] = lane[i];
    end
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = we;
    bus.wbs_dat_i = wdat;
    bus.wbs_sel_i = be;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
  endtask

  // One complete access; the region answers `delay` cycles after it first sees its request.
  task automatic do_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] be, input int delay, input string tag);
    int exp_rgn, ack_k, nsel, exp_lat;
    logic sel_seen, got_we, got_done, exp_done;
    logic [3:0] got_sel, got_be;
    logic [4:0] got_sub;
    logic [11:0] got_off;
    logic [31:0] got_wdata, got_dat, exp_dat;
    logic [7:0] got_err;
    exp_rgn = region_of(adr);
    sel_seen = 1'b0; got_sel = '0; got_be = '0; got_we = 1'b0; got_sub = '0; got_off = '0;
    got_wdata = '0; got_dat = '0; got_done = 1'b0; got_err = '0;
    ack_k = -1; nsel = 0;
    bus_start(adr, we, wdat, be);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      rgn_ack_i = '0;
      if (bus.wbs_ack_o === 1'b1) begin
        ack_k = k; got_dat = bus.wbs_dat_o; got_done = done_pulse_o; got_err = err_cnt_o;
        break;
      end
      if (rgn_sel_o !== 4'b0000) begin
        nsel++;
        if (!sel_seen) begin
          sel_seen = 1'b1; got_sel = rgn_sel_o; got_sub = rgn_sub_o; got_off = rgn_off_o;
          got_we = rgn_we_o; got_be = rgn_be_o; got_wdata = rgn_wdata_o;
        end
        if (nsel == delay) rgn_ack_i = rgn_sel_o;
      end
    end
    bus_idle();
    n_checks++;
    if (ack_k < 0) begin
      n_fail++;
      $display("FAIL %s ack_timeout: no wbs_ack_o within 80 cycles, required one", tag);
    end else begin
      if (!we || exp_rgn < 0) begin
        if (exp_rgn < 0) model_err = (model_err < 255) ? model_err + 1 : 255;
      end
      exp_lat  = (exp_rgn < 0) ? 2 : 2 + delay;
      exp_dat  = (exp_rgn < 0) ? DEADBEEF : (we ? 32'h0 : lane[exp_rgn]);
      exp_done = we && (adr == DONE_A);
      if (ack_k + 1 !== exp_lat) begin
        n_fail++; $display("FAIL %s latency: got %0d required %0d", tag, ack_k + 1, exp_lat);
      end
      n_checks++;
      if (got_dat !== exp_dat) begin
        n_fail++; $display("FAIL %s dat: got %h required %h", tag, got_dat, exp_dat);
      end
      n_checks++;
      if (got_done !== exp_done) begin
        n_fail++; $display("FAIL %s done_pulse: got %b required %b", tag, got_done, exp_done);
      end
      n_checks++;
      if (got_err !== 8'(model_err)) begin
        n_fail++; $display("FAIL %s err_cnt: got %0d required %0d", tag, got_err, model_err);
      end
      n_checks++;
      if (exp_rgn < 0) begin
        if (sel_seen !== 1'b0) begin
          n_fail++; $display("FAIL %s unmapped_sel: got %b required 0000", tag, got_sel);
        end
      end else begin
        if ({got_sel, got_sub, got_off, got_we, got_be, got_wdata} !==
            {4'(1 << exp_rgn), 5'((adr / 16) % 32), 12'(adr % 4096), we, be, wdat}) begin
          n_fail++;
          $display("FAIL %s region_fields: got sel=%b sub=%0d off=%h we=%b be=%b wd=%h required sel=%b sub=%0d off=%h we=%b be=%b wd=%h",
                   tag, got_sel, got_sub, got_off, got_we, got_be, got_wdata,
                   4'(1 << exp_rgn), 5'((adr / 16) % 32), 12'(adr % 4096), we, be, wdat);
        end
      end
      @(negedge clk);
      n_checks++;
      if ({bus.wbs_ack_o, done_pulse_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s one_cycle: ack/done got %b%b required 00", tag, bus.wbs_ack_o, done_pulse_o);
      end
    end
    rgn_ack_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_idle(); rgn_ack_i = '0; rgn_rdata_i = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.wbs_ack_o, bus.wbs_dat_o, done_pulse_o, err_cnt_o} !== 42'h0) begin
      n_fail++;
      $display("FAIL reset_bus: ack=%b dat=%h done=%b err=%0d required all 0",
               bus.wbs_ack_o, bus.wbs_dat_o, done_pulse_o, err_cnt_o);
    end
    n_checks++;
    if ({rgn_sel_o, rgn_sub_o, rgn_off_o, rgn_we_o, rgn_be_o, rgn_wdata_o} !== 58'h0) begin
      n_fail++;
      $display("FAIL reset_rgn: sel=%b sub=%0d off=%h we=%b be=%b wd=%h required all 0",
               rgn_sel_o, rgn_sub_o, rgn_off_o, rgn_we_o, rgn_be_o, rgn_wdata_o);
    end
    rst = 1'b0; model_err = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.wbs_ack_o, rgn_sel_o} !== 5'b0) begin
      n_fail++; $display("FAIL post_reset_idle: ack=%b sel=%b required 0", bus.wbs_ack_o, rgn_sel_o);
    end
  endtask

  task automatic test_directed();
    do_access(32'h3000_1050, 1'b0, 32'h0, 4'hF, 2, "read_rgn1");
    do_access(DONE_A, 1'b1, 32'h1, 4'hF, 1, "write_done");
    do_access(32'h4000_0000, 1'b0, 32'h0, 4'hF, 1, "read_unmapped");
    do_access(32'h3000_0FFC, 1'b1, 32'hCAFE_0001, 4'h3, 3, "write_rgn0_edge");
    do_access(32'h3000_4000, 1'b0, 32'h0, 4'hF, 1, "read_above_window");
    do_access(32'h2FFF_FFFC, 1'b0, 32'h0, 4'hF, 1, "read_below_window");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       a = DONE_A;
        1, 2:    a = $urandom;
        default: a = 32'h3000_0000 | ($urandom & 32'h3FFF);
      endcase
      do_access(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(1, 4)), "random");
    end
  endtask

  task automatic test_spurious();
    int lat;
    bus_start(32'h3000_2080, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      rgn_ack_i = (j == 0) ? 4'b0001 : 4'b1011;
      @(negedge clk);
      n_checks++;
      if ({bus.wbs_ack_o, rgn_sel_o} !== 5'b0_0100) begin
        n_fail++;
        $display("FAIL spurious_ignored: ack=%b sel=%b required ack=0 sel=0100", bus.wbs_ack_o, rgn_sel_o);
      end
    end
    rgn_ack_i = 4'b0100;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rgn_ack_i = '0;
      if (bus.wbs_ack_o === 1'b1) begin lat = k; break; end
    end
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL spurious_completion: ack after %0d cycles, required 2", lat);
    end
    n_checks++;
    if (bus.wbs_dat_o !== lane[2]) begin
      n_fail++; $display("FAIL spurious_dat: got %h required %h", bus.wbs_dat_o, lane[2]);
    end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic test_cyc_drop();
    bus_start(32'h3000_2040, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    n_checks++;
    if (rgn_sel_o !== 4'b0100) begin
      n_fail++; $display("FAIL cyc_drop_req: sel=%b required 0100", rgn_sel_o);
    end
    bus_idle();
    @(negedge clk);
    n_checks++;
    if (rgn_sel_o !== 4'b0000) begin
      n_fail++; $display("FAIL cyc_drop_sel: sel=%b required 0000", rgn_sel_o);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.wbs_ack_o !== 1'b0) begin
        n_fail++; $display("FAIL cyc_drop_noack: ack=%b required 0", bus.wbs_ack_o);
      end
      @(negedge clk);
    end
    do_access(32'h3000_2044, 1'b0, 32'h0, 4'hF, 1, "after_cyc_drop");
  endtask

  task automatic test_reset_mid();
    bus_start(32'h3000_0010, 1'b1, 32'h55AA_55AA, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.wbs_ack_o, rgn_sel_o, err_cnt_o} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_mid: ack=%b sel=%b err=%0d required all 0", bus.wbs_ack_o, rgn_sel_o, err_cnt_o);
    end
    bus_idle(); model_err = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.wbs_ack_o, rgn_sel_o} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_mid_quiet: ack=%b sel=%b required 0", bus.wbs_ack_o, rgn_sel_o);
      end
    end
    do_access(32'h3000_0010, 1'b0, 32'h0, 4'hF, 1, "after_reset_mid");
  endtask

  // stb held high: each access takes 2 cycles to ack plus one cycle re-sample in IDLE.
  task automatic test_back_to_back();
    int n_ack, n_dbl;
    logic prev;
    n_ack = 0; n_dbl = 0; prev = 1'b0;
    bus_start(32'h4000_0000, 1'b0, 32'h0, 4'hF);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) begin
        n_ack++;
        if (prev) n_dbl++;
      end
      prev = bus.wbs_ack_o;
    end
    bus_idle();
    model_err = (model_err + 4 > 255) ? 255 : model_err + 4;
    n_checks++;
    if (n_ack !== 4) begin
      n_fail++; $display("FAIL b2b_ack_count: got %0d required 4", n_ack);
    end
    n_checks++;
    if (n_dbl !== 0) begin
      n_fail++; $display("FAIL b2b_ack_width: %0d multi-cycle acks, required 0", n_dbl);
    end
    n_checks++;
    if (err_cnt_o !== 8'(model_err)) begin
      n_fail++; $display("FAIL b2b_err_cnt: got %0d required %0d", err_cnt_o, model_err);
    end
    @(negedge clk);
  endtask

`ifdef WB_DECODER_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    lat = -1;
    bus_start(32'h3000_1000, 1'b0, 32'h0, 4'hF);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) begin lat = k + 1; break; end
    end
    model_err = (model_err < 255) ? model_err + 1 : 255;
    n_checks++;
    if (lat !== 17) begin
      n_fail++; $display("FAIL timeout_latency: got %0d required 17", lat);
    end
    n_checks++;
    if ({bus.wbs_dat_o, err_cnt_o, rgn_sel_o} !== {DEADBEEF, 8'(model_err), 4'b0000}) begin
      n_fail++;
      $display("FAIL timeout_resp: dat=%h err=%0d sel=%b required %h %0d 0000",
               bus.wbs_dat_o, err_cnt_o, rgn_sel_o, DEADBEEF, model_err);
    end
    bus_idle();
    @(negedge clk);
  endtask
`else
  task automatic test_long_wait();
    do_access(32'h3000_1004, 1'b0, 32'h0, 4'hF, 30, "long_wait");
  endtask
`endif

  task automatic test_err_saturate();
    for (int n = 0; n < 300; n++) begin
      do_access(32'h4000_0000 + 32'(n * 4), 1'b0, 32'h0, 4'hF, 1, "saturate");
    end
    n_checks++;
    if (err_cnt_o !== 8'd255) begin
      n_fail++; $display("FAIL err_saturated: got %0d required 255", err_cnt_o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_spurious();
    test_cyc_drop();
    test_reset_mid();
    test_back_to_back();
`ifdef WB_DECODER_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_err_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
